// File: rtl/sync_pkg.sv
// Shared limits and helpers for the multi-channel input synchroniser.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;
  localparam int FILT_MAX_LEN    = 255;

  // Width of a counter that must hold the value len.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-channel N-flop synchroniser with a per-channel reset level.
module sync_chain
  import sync_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability protection at all.
  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_chain: STAGES out of range");
  end

  logic [STAGES-1:0] stage;

  // Shift the asynchronous bit down the chain; bit 0 is the capture flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {STAGES{RST_VAL}};
    end else begin
      stage[0] <= d;
      for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_multi_filt.sv
// Multi-channel synchroniser with per-channel debounce and edge pulses.
module sync_multi_filt
  import sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  localparam int            CW       = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_multi_filt: WIDTH out of range");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > FILT_MAX_LEN) begin : g_bad_len
    $error("sync_multi_filt: FILTER_LEN out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic          filt_q, rise_q, fall_q;
    logic [CW-1:0] cnt;

    sync_chain #(
      .STAGES  (STAGES),
      .RST_VAL (RESET_VALUE[i])
    ) u_chain (
      .clk (clk),
      .rst (rst),
      .d   (async_in[i]),
      .q   (sync_out[i])
    );

    // Debounce: follow sync_out only after FILTER_LEN consecutive differing
    // samples. An unknown sync_out matches neither branch, so in simulation
    // it freezes the counter and filt_q instead of poisoning them.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q <= RESET_VALUE[i];
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync_out[i] == filt_q) begin
          cnt <= '0;
        end else if (sync_out[i] != filt_q) begin
          if (cnt == CNT_LAST) begin
            filt_q <= sync_out[i];
            cnt    <= '0;
            rise_q <= sync_out[i];
            fall_q <= ~sync_out[i];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end

    assign filt_out[i] = filt_q;
    assign rise_out[i] = rise_q;
    assign fall_out[i] = fall_q;
  end

endmodule
